// File: rtl/pq_sorted_array.sv
// Sorted-array priority queue: index 0 is the head, equal priorities keep push order.
// Each accepted request walks IDLE -> EXEC -> DONE; the array is rewritten at the end of EXEC.
module pq_sorted_array #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned IW       = 4,
  parameter int unsigned PW       = 4,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [IW-1:0]              push_id_i,
  input  logic [PW-1:0]              push_prio_i,
  input  logic                       pop_i,
  input  logic                       drop_i,
  input  logic [IW-1:0]              drop_id_i,
  output logic                       op_rdy_o,
  output logic                       done_o,
  output logic [IW-1:0]              res_id_o,
  output logic [PW-1:0]              res_prio_o,
  output logic                       pop_vld_o,
  output logic                       drop_hit_o,
  output logic                       evict_o,
  output logic                       err_o,
  output logic                       peek_vld_o,
  output logic [IW-1:0]              peek_id_o,
  output logic [PW-1:0]              peek_prio_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned XW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
  typedef enum logic [1:0] {OpPush, OpPop, OpPushPop, OpDrop} op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [IW-1:0] arg_id_q, arg_id_d;
  logic [PW-1:0] arg_prio_q, arg_prio_d;
  logic [IW-1:0] ids_q [DEPTH];
  logic [IW-1:0] ids_d [DEPTH];
  logic [PW-1:0] prios_q [DEPTH];
  logic [PW-1:0] prios_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] res_id_q, res_id_d;
  logic [PW-1:0] res_prio_q, res_prio_d;
  logic          pop_vld_q, pop_vld_d, drop_hit_q, drop_hit_d;
  logic          evict_q, evict_d, err_q, err_d;

  logic          is_full, is_empty, hit;
  logic [XW-1:0] hit_idx, rem_idx;
  logic          do_rem, do_ins;
  logic          r_pop, r_hit, r_ev, r_err;
  logic [IW-1:0] r_id;
  logic [PW-1:0] r_prio;
  logic [IW-1:0] rm_ids [DEPTH];
  logic [PW-1:0] rm_prios [DEPTH];
  logic [IW-1:0] in_ids [DEPTH];
  logic [PW-1:0] in_prios [DEPTH];
  int            c1, c2, pos;

  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);

  // Lowest matching index is the highest-priority (and oldest) entry with that ID.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && i < int'(cnt_q) && arg_id_q != '0 && ids_q[i] == arg_id_q) begin
        hit     = 1'b1;
        hit_idx = XW'(i);
      end
    end
  end

  always_comb begin
    do_rem = 1'b0;
    do_ins = 1'b0;
    r_pop  = 1'b0;
    r_hit  = 1'b0;
    r_ev   = 1'b0;
    r_err  = 1'b0;
    r_id   = '0;
    r_prio = '0;
    unique case (op_q)
      OpPush: begin
        if (arg_id_q == '0) begin
          r_err = 1'b1;
        end else if (is_full) begin
          if (OVF_MODE != 0 && arg_prio_q > prios_q[DEPTH-1]) begin
            do_ins = 1'b1;
            r_ev   = 1'b1;
            r_id   = ids_q[DEPTH-1];
            r_prio = prios_q[DEPTH-1];
          end else begin
            r_err = 1'b1;
          end
        end else begin
          do_ins = 1'b1;
        end
      end
      OpPop: begin
        if (is_empty) begin
          r_err = 1'b1;
        end else begin
          do_rem = 1'b1;
          r_pop  = 1'b1;
          r_id   = ids_q[0];
          r_prio = prios_q[0];
        end
      end
      OpPushPop: begin
        r_pop = 1'b1;
        // A push that would become the head is handed straight back.
        if (is_empty || arg_prio_q > prios_q[0]) begin
          r_id   = arg_id_q;
          r_prio = arg_prio_q;
        end else begin
          do_rem = 1'b1;
          do_ins = 1'b1;
          r_id   = ids_q[0];
          r_prio = prios_q[0];
        end
      end
      OpDrop: begin
        if (hit) begin
          do_rem = 1'b1;
          r_hit  = 1'b1;
          r_id   = ids_q[hit_idx];
          r_prio = prios_q[hit_idx];
        end
      end
      default: ;
    endcase
  end

  assign rem_idx = (op_q == OpDrop) ? hit_idx : '0;

  // Removal first, then insertion into the compacted array.
  always_comb begin
    rm_ids   = ids_q;
    rm_prios = prios_q;
    c1       = int'(cnt_q);
    if (do_rem) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(rem_idx)) begin
          rm_ids[i]   = ids_q[i+1];
          rm_prios[i] = prios_q[i+1];
        end
      end
      rm_ids[DEPTH-1]   = '0;
      rm_prios[DEPTH-1] = '0;
      c1 = c1 - 1;
    end
    pos = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < c1 && rm_prios[i] >= arg_prio_q) pos = pos + 1;
    end
    in_ids   = rm_ids;
    in_prios = rm_prios;
    c2       = c1;
    if (do_ins) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (i > pos) begin
          in_ids[i]   = rm_ids[i-1];
          in_prios[i] = rm_prios[i-1];
        end else if (i == pos) begin
          in_ids[i]   = arg_id_q;
          in_prios[i] = arg_prio_q;
        end
      end
      if (pos == 0) begin
        in_ids[0]   = arg_id_q;
        in_prios[0] = arg_prio_q;
      end
      if (c1 < DEPTH) c2 = c1 + 1;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_id_d   = arg_id_q;
    arg_prio_d = arg_prio_q;
    ids_d      = ids_q;
    prios_d    = prios_q;
    cnt_d      = cnt_q;
    res_id_d   = res_id_q;
    res_prio_d = res_prio_q;
    pop_vld_d  = pop_vld_q;
    drop_hit_d = drop_hit_q;
    evict_d    = evict_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (push_i || pop_i || drop_i) begin
          state_d    = StExec;
          arg_id_d   = push_id_i;
          arg_prio_d = push_prio_i;
          if (push_i && pop_i) begin
            op_d = OpPushPop;
          end else if (drop_i) begin
            op_d     = OpDrop;
            arg_id_d = drop_id_i;
          end else if (pop_i) begin
            op_d = OpPop;
          end else begin
            op_d = OpPush;
          end
        end
      end
      StExec: begin
        state_d    = StDone;
        ids_d      = in_ids;
        prios_d    = in_prios;
        cnt_d      = CW'(c2);
        res_id_d   = r_id;
        res_prio_d = r_prio;
        pop_vld_d  = r_pop;
        drop_hit_d = r_hit;
        evict_d    = r_ev;
        err_d      = r_err;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= OpPush;
      arg_id_q   <= '0;
      arg_prio_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ids_q[i]   <= '0;
        prios_q[i] <= '0;
      end
      cnt_q      <= '0;
      res_id_q   <= '0;
      res_prio_q <= '0;
      pop_vld_q  <= 1'b0;
      drop_hit_q <= 1'b0;
      evict_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_id_q   <= arg_id_d;
      arg_prio_q <= arg_prio_d;
      ids_q      <= ids_d;
      prios_q    <= prios_d;
      cnt_q      <= cnt_d;
      res_id_q   <= res_id_d;
      res_prio_q <= res_prio_d;
      pop_vld_q  <= pop_vld_d;
      drop_hit_q <= drop_hit_d;
      evict_q    <= evict_d;
      err_q      <= err_d;
    end
  end

  assign op_rdy_o    = (state_q == StIdle);
  assign done_o      = (state_q == StDone);
  assign res_id_o    = done_o ? res_id_q : '0;
  assign res_prio_o  = done_o ? res_prio_q : '0;
  assign pop_vld_o   = done_o & pop_vld_q;
  assign drop_hit_o  = done_o & drop_hit_q;
  assign evict_o     = done_o & evict_q;
  assign err_o       = done_o & err_q;
  assign peek_vld_o  = !is_empty;
  assign peek_id_o   = ids_q[0];
  assign peek_prio_o = prios_q[0];
  assign full_o      = is_full;
  assign empty_o     = is_empty;
  assign count_o     = cnt_q;

endmodule

// File: doc/pq_sorted_array.md
PQ_SORTED_ARRAY -- requirements
Module: pq_sorted_array

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of entries (>=2).
REQ-002 SHALL have parameter IW, 4, ID width; ID 0 is reserved as "no entry".
REQ-003 SHALL have parameter PW, 4, priority width; a larger value means higher priority.
REQ-004 SHALL have parameter OVF_MODE, 0, full-push policy: 0 = reject, 1 = evict lowest.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, asynchronous active-low reset.
REQ-006 SHALL have ports push_i input 1, push request; push_id_i input IW; push_prio_i input PW.
REQ-007 SHALL have ports pop_i input 1, pop request; drop_i input 1, drop request; drop_id_i input IW, ID to remove.
REQ-008 SHALL have output op_rdy_o 1, request-accept indication.
REQ-009 SHALL have outputs done_o 1, one-cycle completion pulse; res_id_o IW and res_prio_o PW, popped/evicted/dropped entry.
REQ-010 SHALL have outputs pop_vld_o 1, drop_hit_o 1, evict_o 1 and err_o 1, result qualifiers valid with done_o.
REQ-011 SHALL have outputs peek_vld_o 1, peek_id_o IW and peek_prio_o PW, giving the head entry.
REQ-012 SHALL have outputs full_o 1, empty_o 1 and count_o $clog2(DEPTH+1), occupancy.

Function
REQ-013 SHALL keep entries sorted by priority, index 0 being the head; equal priorities SHALL stay in push order (FIFO tie-break).
REQ-014 SHALL implement an FSM with states IDLE -> EXEC -> DONE -> IDLE; op_rdy_o=1 only in IDLE.
REQ-015 SHALL accept a request only in IDLE with any request high, and capture the operands at that edge; requests are ignored otherwise.
REQ-016 SHALL decode simultaneous requests as: push&pop -> PUSH_POP; otherwise drop > pop > push.
REQ-017 SHALL update the array during EXEC, and SHALL pulse done_o plus the qualifiers in DONE only (latency: done_o 2 cycles after accept).
REQ-018 SHALL, on PUSH, insert behind all entries of priority >= push_prio_i, shifting lower entries down by one.
REQ-019 SHALL, on PUSH when full with OVF_MODE=0, leave the array unchanged and set err_o=1.
REQ-020 SHALL, on PUSH when full with OVF_MODE=1 and push_prio_i > tail priority, insert the entry, discard the tail, set evict_o=1 and return the tail on res_*; otherwise SHALL treat the push as OVF_MODE=0.
REQ-021 SHALL treat a PUSH with push_id_i=0 as err_o=1, with no array change.
REQ-022 SHALL, on POP, remove the head, shift the others up, set pop_vld_o=1 and return the head on res_*; POP when empty SHALL give pop_vld_o=0, err_o=1, res_*=0.
REQ-023 SHALL, on PUSH_POP with push_prio_i > head priority or with the queue empty, bypass: res_* = pushed entry, pop_vld_o=1, array unchanged.
REQ-024 SHALL, on any other PUSH_POP, pop the head and insert the pushed entry in one operation, leaving count unchanged.
REQ-025 SHALL, on DROP, remove the highest-priority entry whose ID equals drop_id_i, close the gap, set drop_hit_o=1 and return that entry.
REQ-026 SHALL, on a DROP with no match or drop_id_i=0, leave the array unchanged with drop_hit_o=0 and err_o=0.
REQ-027 SHALL drive peek_*, full_o, empty_o and count_o combinationally from the array, updated the cycle after EXEC; peek_id_o=0 and peek_prio_o=0 when empty.
REQ-028 SHALL zero res_* and all qualifiers outside DONE.

Reset
REQ-029 SHALL, on rst_ni low at any time including mid-operation, asynchronously clear all entries to ID 0/priority 0, set state IDLE, and abort any captured operation without a done_o pulse.
REQ-030 SHALL hold these output values during reset: op_rdy_o=1, empty_o=1, all other outputs 0.

Verification
REQ-031 SHALL cover: push (id3,p2), (id5,p7), (id6,p2) -> peek id5; pops return id5, id3, id6 in that order.
REQ-032 SHALL cover: DEPTH=8 queue full, OVF_MODE=0, push p9 -> err_o=1, count_o stays 8; with OVF_MODE=1, push p9 against tail p1 -> evict_o=1 and res_prio_o=1.
REQ-033 SHALL cover: head p4, push&pop same cycle with (id9,p6) -> res_id_o=9, count unchanged; then with (id9,p1) -> res = old head, id9 queued.
REQ-034 SHALL cover: queue {id2,id7,id4}, drop id7 -> drop_hit_o=1, order becomes id2,id4; drop id15 -> drop_hit_o=0, no change.
REQ-035 SHALL cover: pop on empty -> err_o=1 and pop_vld_o=0; a request while not in IDLE -> ignored, with a single done_o.
REQ-036 SHALL cover: rst_ni asserted during EXEC -> no done_o, count_o=0 and op_rdy_o=1 immediately.
